// File: rtl/seven_seg_scan_mux.sv
// Scans an N-digit hex value onto one shared seven-segment decoder and common-anode display.
// A blank gap separates digits. New values are double-buffered and swapped in at frame boundaries.
module seven_seg_scan_mux #(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   value,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    lzs_en,
   output logic [3:0]              digit,
   output logic [N_DIGITS-1:0]     an,
   output logic                    blank,
   output logic                    dp,
   output logic                    updated
);

   localparam int IW      = $clog2(N_DIGITS);
   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CW-1:0]           r_cnt, w_cnt_nxt;
   logic [IW-1:0]           r_idx, w_idx_nxt;
   logic                    w_boundary;

   logic [4*N_DIGITS-1:0]   r_disp_val, r_pend_val;
   logic [N_DIGITS-1:0]     r_disp_dp, r_pend_dp;
   logic                    r_pend_valid;
   logic                    r_updated;
   logic                    r_lzs;

   logic [N_DIGITS-1:0]     w_lead_zero;
   logic                    w_acc;
   logic                    w_supp;
   logic                    w_lit;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_boundary  = 1'b0;
      case (r_state)
         ST_BLANK: begin
            if (r_cnt == CW'(BLANK_CYCLES-1)) begin
               w_state_nxt = ST_SHOW;
               w_cnt_nxt   = '0;
            end
         end
         ST_SHOW: begin
            if (r_cnt == CW'(REFRESH_DIV-1)) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               if (r_idx == IW'(N_DIGITS-1)) begin
                  w_idx_nxt  = '0;
                  w_boundary = 1'b1;
               end else begin
                  w_idx_nxt  = r_idx + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Transfer uses the old pending contents; a coincident load refills pending and keeps it valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_disp_val   <= '0;
         r_disp_dp    <= '0;
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_valid <= 1'b0;
         r_updated    <= 1'b0;
         r_lzs        <= 1'b0;
      end else begin
         r_lzs     <= lzs_en;
         r_updated <= w_boundary && r_pend_valid;
         if (w_boundary && r_pend_valid) begin
            r_disp_val <= r_pend_val;
            r_disp_dp  <= r_pend_dp;
         end
         if (load) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp_in;
            r_pend_valid <= 1'b1;
         end else if (w_boundary) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   // w_lead_zero[i]: nibbles N_DIGITS-1 down to i of the displayed value are all zero.
   always_comb begin
      w_lead_zero = '0;
      w_acc       = 1'b1;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
         w_acc = w_acc & (r_disp_val[4*(N_DIGITS-1-k) +: 4] == 4'h0);
         w_lead_zero[N_DIGITS-1-k] = w_acc;
      end
   end

   assign w_supp  = r_lzs && (r_idx != '0) && w_lead_zero[r_idx];
   assign w_lit   = (r_state == ST_SHOW) && !w_supp;

   assign digit   = (r_state == ST_SHOW) ? r_disp_val[{r_idx, 2'b00} +: 4] : 4'h0;
   assign an      = w_lit ? ~(N_DIGITS'(1) << r_idx) : '1;
   assign blank   = ~w_lit;
   assign dp      = w_lit ? ~r_disp_dp[r_idx] : 1'b1;
   assign updated = r_updated;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seven_seg_scan_mux;

   localparam int N = 4;
   localparam int R = 4;
   localparam int B = 2;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        load   = 1'b0;
   logic        lzs_en = 1'b0;
   logic [15:0] value  = '0;
   logic [3:0]  dp_in  = '0;
   logic [3:0]  digit;
   logic [3:0]  an;
   logic        blank;
   logic        dp;
   logic        updated;

   int n_vec = 0;
   int n_err = 0;

   seven_seg_scan_mux #(
      .N_DIGITS     (N),
      .REFRESH_DIV  (R),
      .BLANK_CYCLES (B)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .value   (value),
      .dp_in   (dp_in),
      .lzs_en  (lzs_en),
      .digit   (digit),
      .an      (an),
      .blank   (blank),
      .dp      (dp),
      .updated (updated)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // exp packs {an, blank, digit, dp, updated}
   task automatic chk(input string tag, input int f, input logic [10:0] exp);
      logic [10:0] obs;
      obs = {an, blank, digit, dp, updated};
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s f=%0d observed an=%b blank=%b digit=%h dp=%b upd=%b expected an=%b blank=%b digit=%h dp=%b upd=%b",
                tag, f, obs[10:7], obs[6], obs[5:2], obs[1], obs[0],
                exp[10:7], exp[6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   // Frame cycle f: f%6 in {0,1} is the gap, otherwise digit f/6 is shown.
   task automatic run_frame(input string tag, input int ncyc,
                            input logic [15:0] val, input logic [3:0] dpv,
                            input logic lz, input logic upd0,
                            input int lf1, input logic [15:0] lv1, input logic [3:0] ld1,
                            input int lf2, input logic [15:0] lv2, input logic [3:0] ld2);
      for (int f = 0; f < ncyc; f++) begin
         int          pos;
         int          ix;
         logic [3:0]  nib;
         logic        supp;
         logic [10:0] e;
         pos  = f % 6;
         ix   = f / 6;
         nib  = 4'(val >> (4*ix));
         supp = lz && (ix > 0) && ((val >> (4*ix)) == 16'h0);
         if (pos < 2 || supp)
            e = {4'b1111, 1'b1, 4'h0, 1'b1, 1'b0};
         else
            e = {~(4'b0001 << ix), 1'b0, nib, ~dpv[ix], 1'b0};
         e[0] = (f == 0) && upd0;
         chk(tag, f, e);
         if (f == 0) lzs_en = lz;
         load = (f == lf1) || (f == lf2);
         if (f == lf1) begin value = lv1; dp_in = ld1; end
         if (f == lf2) begin value = lv2; dp_in = ld2; end
         tick();
         load = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      tick();
      tick();
      chk("reset_hold", 0, {4'b1111, 1'b1, 4'h0, 1'b1, 1'b0});
      reset = 1'b0;

      run_frame("idle_frame", 24, 16'h0000, 4'b0000, 1'b0, 1'b0,
                3, 16'h1A3F, 4'b0100, -1, 16'h0, 4'h0);
      run_frame("show_1A3F", 24, 16'h1A3F, 4'b0100, 1'b0, 1'b1,
                5, 16'h0050, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("lzs_0050", 24, 16'h0050, 4'b0000, 1'b1, 1'b1,
                5, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("lzs_0000", 24, 16'h0000, 4'b0000, 1'b1, 1'b1,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame("nolzs_hold", 24, 16'h0000, 4'b0000, 1'b0, 1'b0,
                3, 16'h1111, 4'b0000, 10, 16'h2222, 4'b0000);
      run_frame("two_loads", 24, 16'h2222, 4'b0000, 1'b0, 1'b1,
                7, 16'h1111, 4'b0000, 23, 16'h2222, 4'b0000);
      run_frame("coinc_old", 24, 16'h1111, 4'b0000, 1'b0, 1'b1,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame("coinc_new", 24, 16'h2222, 4'b0000, 1'b0, 1'b1,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame("pre_reset", 15, 16'h2222, 4'b0000, 1'b0, 1'b0,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      chk("show_idx2", 15, {4'b1011, 1'b0, 4'h2, 1'b1, 1'b0});

      reset = 1'b1;
      tick();
      chk("mid_reset", 0, {4'b1111, 1'b1, 4'h0, 1'b1, 1'b0});
      reset = 1'b0;
      run_frame("post_reset", 24, 16'h0000, 4'b0000, 1'b0, 1'b0,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
